// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin arbitrated UART transmit serializer
// One framed byte at a time: start, data LSB-first, optional parity, stop bit(s).
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                            pclk,
  input  logic                            areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            bclk,
  output logic                            tx
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BAUD_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;

  logic                  found;
  logic [GW-1:0]         winner;
  logic [GW:0]           idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  baud_last;

  // Search starts just after the last winner and wraps, giving round-robin order.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    sel_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (!found && req_valid[idx[GW-1:0]]) begin
        found  = 1'b1;
        winner = idx[GW-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign baud_last  = (baud_q == BW'(BAUD_DIV-1));
  assign busy       = (state_q != IDLE);
  assign bclk       = busy && (baud_q < BW'(BAUD_DIV/2));
  assign frame_done = (state_q == STOP) && baud_last && (bit_q == 3'(STOP_BITS-1));
  assign grant_id   = grant_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    grant_d   = grant_q;
    last_d    = last_q;
    req_ready = '0;
    tx        = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (found) begin
          // Ready is masked while reset is held so no accept is signalled then.
          req_ready[winner] = ~areset;
          shift_d = sel_data;
          par_d   = (^sel_data) ^ (PARITY_ODD != 0);
          grant_d = winner;
          last_d  = winner;
          state_d = START;
        end
      end
      default: begin
        baud_d = baud_last ? '0 : baud_q + BW'(1);
        case (state_q)
          START:   tx = 1'b0;
          DATA:    tx = shift_q[0];
          PARITY:  tx = par_q;
          default: tx = 1'b1;
        endcase
        if (baud_last) begin
          case (state_q)
            START: begin
              state_d = DATA;
              bit_d   = '0;
            end
            DATA: begin
              shift_d = shift_q >> 1;
              if (bit_q == 3'(DATA_WIDTH-1)) begin
                bit_d   = '0;
                state_d = (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            PARITY: begin
              state_d = STOP;
              bit_d   = '0;
            end
            default: begin
              if (bit_q == 3'(STOP_BITS-1)) begin
                state_d = IDLE;
                bit_d   = '0;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ-1);
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
// Directed vector table, randomized frames against a frame-level model, reset and 2-stop corners.
module tb_uart_tx_scheduler;
  localparam int BD = 16;

  logic        pclk = 1'b0;
  logic        areset;
  logic [3:0]  rv1, rv2;
  logic [31:0] rd1, rd2;
  logic [3:0]  rr1, rr2;
  logic [1:0]  gid1, gid2;
  logic        busy1, busy2, fd1, fd2, bclk1, bclk2, tx1, tx2;
  bit          use2;

  logic [3:0]  rr_m;
  logic [1:0]  gid_m;
  logic        busy_m, fd_m, bclk_m, tx_m;

  int n_chk = 0;
  int n_err = 0;
  int mlast[2];

  always #5 pclk = ~pclk;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(1),
                      .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .pclk(pclk), .areset(areset), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .grant_id(gid1), .busy(busy1), .frame_done(fd1), .bclk(bclk1), .tx(tx1));

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_WIDTH(8), .BAUD_DIV(BD), .PARITY_EN(1),
                      .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .pclk(pclk), .areset(areset), .req_valid(rv2), .req_data(rd2), .req_ready(rr2),
    .grant_id(gid2), .busy(busy2), .frame_done(fd2), .bclk(bclk2), .tx(tx2));

  assign rr_m   = use2 ? rr2   : rr1;
  assign gid_m  = use2 ? gid2  : gid1;
  assign busy_m = use2 ? busy2 : busy1;
  assign fd_m   = use2 ? fd2   : fd1;
  assign bclk_m = use2 ? bclk2 : bclk1;
  assign tx_m   = use2 ? tx2   : tx1;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_w;
    logic [7:0]  exp_b;
    bit          scr;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_in(input logic [3:0] m, input logic [31:0] d);
    if (use2) begin rv2 = m; rd2 = d; end
    else begin rv1 = m; rd1 = d; end
  endtask

  task automatic run_frame(input int w, input logic [7:0] b, input bit scr);
    logic bits[$];
    int   len, odd, stops;
    odd   = use2 ? 1 : 0;
    stops = use2 ? 2 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    bits.push_back((^b) ^ odd[0]);
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    len = bits.size() * BD;
    for (int c = 0; c < len; c++) begin
      @(negedge pclk);
      if (scr) set_in(4'($urandom), $urandom);
      #1;
      chk("frame_tx", 32'(tx_m), 32'(bits[c / BD]));
      chk("frame_bclk", 32'(bclk_m), 32'((c % BD) < BD / 2));
      chk("frame_busy", 32'(busy_m), 32'd1);
      chk("frame_done", 32'(fd_m), 32'(c == len - 1));
      chk("frame_ready", 32'(rr_m), 32'd0);
      chk("frame_gid", 32'(gid_m), 32'(w));
    end
  endtask

  task automatic grant_cycle(input logic [3:0] m, input logic [31:0] d, input bit scr,
                             input int exp_w, input logic [7:0] exp_b);
    set_in(m, d);
    #1;
    chk("idle_busy", 32'(busy_m), 32'd0);
    chk("idle_tx", 32'(tx_m), 32'd1);
    chk("idle_bclk", 32'(bclk_m), 32'd0);
    chk("grant_ready", 32'(rr_m), (exp_w < 0) ? 32'd0 : (32'd1 << exp_w));
    if (exp_w >= 0) begin
      mlast[use2 ? 1 : 0] = exp_w;
      run_frame(exp_w, exp_b, scr);
    end
  endtask

  task automatic idle_step(input logic [3:0] m, input logic [31:0] d, input bit scr,
                           input int exp_w, input logic [7:0] exp_b);
    @(negedge pclk);
    grant_cycle(m, d, scr, exp_w, exp_b);
  endtask

  initial begin
    logic [3:0]  m;
    logic [31:0] d;
    int          w;
    logic [7:0]  rb;

    tbl[0] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5, 1'b0};
    tbl[1] = '{4'b1111, 32'hD4C3_B2A1, 1, 8'hB2, 1'b0};
    tbl[2] = '{4'b1111, 32'hD4C3_B2A1, 2, 8'hC3, 1'b0};
    tbl[3] = '{4'b1111, 32'hD4C3_B2A1, 3, 8'hD4, 1'b0};
    tbl[4] = '{4'b1111, 32'hD4C3_B2A1, 0, 8'hA1, 1'b0};
    tbl[5] = '{4'b0100, 32'h003C_0000, 2, 8'h3C, 1'b0};
    tbl[6] = '{4'b1001, 32'h8100_007E, 3, 8'h81, 1'b0};
    tbl[7] = '{4'b1001, 32'h8100_007E, 0, 8'h7E, 1'b1};

    use2 = 1'b0;
    mlast[0] = 3;
    mlast[1] = 3;
    areset = 1'b1;
    rv1 = 4'hF; rv2 = 4'hF; rd1 = '0; rd2 = '0;
    @(negedge pclk);
    #1;
    chk("rst_tx", 32'(tx1), 32'd1);
    chk("rst_bclk", 32'(bclk1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(fd1), 32'd0);
    chk("rst_ready", 32'(rr1), 32'd0);
    chk("rst_gid", 32'(gid1), 32'd0);
    @(negedge pclk);
    rv1 = '0; rv2 = '0;
    areset = 1'b0;

    for (int i = 0; i < 8; i++)
      idle_step(tbl[i].valid, tbl[i].data, tbl[i].scr, tbl[i].exp_w, tbl[i].exp_b);

    for (int i = 0; i < 20; i++) begin
      m  = 4'($urandom_range(0, 15));
      d  = $urandom;
      w  = model_winner(m, mlast[0]);
      rb = (w >= 0) ? d[w*8 +: 8] : 8'h00;
      idle_step(m, d, 1'($urandom_range(0, 1)), w, rb);
    end

    idle_step(4'b0001, 32'h0000_005A, 1'b0, 0, 8'h5A);
    @(negedge pclk);
    set_in(4'b0011, 32'h0000_C600);
    #1;
    chk("rst_seq_ready", 32'(rr1), 32'b0010);
    mlast[0] = 1;
    rb = 8'hC6;
    for (int c = 0; c < 5 * BD + 3; c++) begin
      @(negedge pclk);
      #1;
      chk("rst_seq_tx", 32'(tx1), (c < BD) ? 32'd0 : 32'(rb[c / BD - 1]));
    end
    @(negedge pclk);
    areset = 1'b1;
    #1;
    chk("abort_tx", 32'(tx1), 32'd1);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_bclk", 32'(bclk1), 32'd0);
    chk("abort_ready", 32'(rr1), 32'd0);
    chk("abort_gid", 32'(gid1), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      #1;
      chk("abort_done", 32'(fd1), 32'd0);
      chk("abort_tx_hold", 32'(tx1), 32'd1);
    end
    mlast[0] = 3;
    @(negedge pclk);
    areset = 1'b0;
    grant_cycle(4'b0011, 32'h0000_C6A3, 1'b0, model_winner(4'b0011, mlast[0]), 8'hA3);

    use2 = 1'b1;
    idle_step(4'b0001, 32'h0000_0000, 1'b0, model_winner(4'b0001, mlast[1]), 8'h00);
    idle_step(4'b0110, 32'h00E7_1900, 1'b1, model_winner(4'b0110, mlast[1]), 8'h19);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
